// File: rtl/multi_button_detector.sv
// multi_button_detector
//   N_CH independent push-button channels. Each channel runs a 2-FF
//   synchroniser, a counter debouncer and a registered edge stage. The edge
//   stage produces press/release pulses, a long-press pulse after
//   HOLD_CYCLES and optional auto-repeat pulses every REPEAT_CYCLES after that.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active low
//   btn_in         raw asynchronous button inputs, active high
//   level          debounced button level
//   press          one-cycle pulse on debounced 0->1
//   release_pulse  one-cycle pulse on debounced 1->0
//   long_press     one-cycle pulse HOLD_CYCLES after press while held
//   repeat_pulse   one-cycle pulses every REPEAT_CYCLES after long_press
//   any_press      OR of press, coincident with press
//
// The release and repeat outputs carry a _pulse suffix because "release"
// and "repeat" are reserved words in SystemVerilog.
module multi_button_detector #(
    parameter int N_CH          = 4,
    parameter int DB_CYCLES     = 4,
    parameter int HOLD_CYCLES   = 10,
    parameter int REPEAT_CYCLES = 3,
    parameter int REPEAT_EN     = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] repeat_pulse,
    output logic            any_press
);

    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    logic [N_CH-1:0] s1, s2, prev;
    logic [DW-1:0]   dcnt [N_CH];
    logic [HW-1:0]   hcnt [N_CH];
    logic [RW-1:0]   rcnt [N_CH];
    logic [N_CH-1:0] rep_active;

    logic [N_CH-1:0] press_next, release_next, long_next, repeat_next;

    always_comb begin
        press_next   = level & ~prev;
        release_next = ~level & prev;
        long_next    = '0;
        repeat_next  = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            // hcnt is still 0 in the press cycle, so gate with press_next to
            // keep HOLD_CYCLES=1 from firing together with press.
            long_next[c]   = level[c] & ~press_next[c] &
                             (hcnt[c] == HW'(HOLD_CYCLES - 1));
            repeat_next[c] = (REPEAT_EN != 0) && rep_active[c] && level[c] &&
                             (rcnt[c] == RW'(REPEAT_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1            <= '0;
            s2            <= '0;
            prev          <= '0;
            level         <= '0;
            press         <= '0;
            release_pulse <= '0;
            long_press    <= '0;
            repeat_pulse  <= '0;
            any_press     <= 1'b0;
            rep_active    <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                dcnt[c] <= '0;
                hcnt[c] <= '0;
                rcnt[c] <= '0;
            end
        end else begin
            s1            <= btn_in;
            s2            <= s1;
            prev          <= level;
            press         <= press_next;
            release_pulse <= release_next;
            long_press    <= long_next;
            repeat_pulse  <= repeat_next;
            any_press     <= |press_next;

            for (int unsigned c = 0; c < N_CH; c++) begin
                // Debounce: count consecutive samples that disagree with level.
                if (s2[c] == level[c]) begin
                    dcnt[c] <= '0;
                end else if (dcnt[c] == DW'(DB_CYCLES - 1)) begin
                    level[c] <= s2[c];
                    dcnt[c]  <= '0;
                end else begin
                    dcnt[c] <= dcnt[c] + 1'b1;
                end

                // Hold counter saturates at HOLD_CYCLES so long_press fires once.
                if (!level[c] || press_next[c]) begin
                    hcnt[c] <= '0;
                end else if (hcnt[c] != HW'(HOLD_CYCLES)) begin
                    hcnt[c] <= hcnt[c] + 1'b1;
                end

                // Repeat phase starts at long_press and ends when level drops.
                if (!level[c]) begin
                    rep_active[c] <= 1'b0;
                    rcnt[c]       <= '0;
                end else if (long_next[c]) begin
                    rep_active[c] <= 1'b1;
                    rcnt[c]       <= '0;
                end else if (rep_active[c]) begin
                    rcnt[c] <= repeat_next[c] ? '0 : rcnt[c] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_button_detector.sv
module tb_multi_button_detector;

    localparam int N    = 4;
    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] btn_in = '0;

    logic [N-1:0] level, press, rel, lng, rep;
    logic         anyp;
    logic [N-1:0] level_nr, press_nr, rel_nr, lng_nr, rep_nr;
    logic         anyp_nr;

    always #5 clk = ~clk;

    multi_button_detector #(
        .N_CH(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .REPEAT_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .level(level), .press(press), .release_pulse(rel),
        .long_press(lng), .repeat_pulse(rep), .any_press(anyp)
    );

    multi_button_detector #(
        .N_CH(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .REPEAT_EN(0)
    ) dut_nr (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .level(level_nr), .press(press_nr), .release_pulse(rel_nr),
        .long_press(lng_nr), .repeat_pulse(rep_nr), .any_press(anyp_nr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: level flips once the last DB synchronised samples
    // (btn_in two edges late) all disagree with it; pulse timing is derived
    // from the number of edges elapsed since the press edge.
    bit [N-1:0] hq[$];
    bit [N-1:0] m_lvl, m_lvl_d, m_press, m_rel, m_long, m_rep;
    bit         m_held [N];
    int         m_t    [N];

    function automatic bit s2_at(input int j, input int c);
        int idx = j + 2;
        if (idx < hq.size()) return hq[idx][c];
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            hq.delete();
            m_lvl = '0; m_lvl_d = '0; m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
            for (int c = 0; c < N; c++) begin m_held[c] = 0; m_t[c] = 0; end
        end else begin
            hq.push_front(btn_in);
            if (hq.size() > 16) void'(hq.pop_back());
            for (int c = 0; c < N; c++) begin
                bit lp, lpp, flip;
                lp   = m_lvl[c];
                lpp  = m_lvl_d[c];
                flip = 1'b1;
                for (int j = 0; j < DB; j++) if (s2_at(j, c) == lp) flip = 1'b0;
                m_press[c] = lp & ~lpp;
                m_rel[c]   = ~lp & lpp;
                if (m_press[c]) begin m_held[c] = 1; m_t[c] = 0; end
                else if (!lp) m_held[c] = 0;
                else if (m_held[c]) m_t[c]++;
                m_long[c] = m_held[c] && lp && !m_press[c] && (m_t[c] == HOLD);
                m_rep[c]  = m_held[c] && lp && (m_t[c] > HOLD) && ((m_t[c] - HOLD) % REP == 0);
                m_lvl_d[c] = lp;
                m_lvl[c]   = flip ? ~lp : lp;
            end
        end
    end

    // Pulse counters over a phase, taken from the DUT outputs.
    int cnt_press [N];
    int cnt_long  [N];
    int cnt_rep   [N];
    int cnt_long_nr, cnt_rep_nr, cnt_any;

    task automatic clear_counts();
        for (int c = 0; c < N; c++) begin cnt_press[c] = 0; cnt_long[c] = 0; cnt_rep[c] = 0; end
        cnt_long_nr = 0; cnt_rep_nr = 0; cnt_any = 0;
    endtask

    task automatic compare_all();
        check("level",      level, m_lvl);
        check("press",      press, m_press);
        check("release",    rel,   m_rel);
        check("long_press", lng,   m_long);
        check("repeat",     rep,   m_rep);
        check("any_press",  anyp,  |m_press);
        check("nr_level",   level_nr, m_lvl);
        check("nr_press",   press_nr, m_press);
        check("nr_release", rel_nr,   m_rel);
        check("nr_long",    lng_nr,   m_long);
        check("nr_repeat",  rep_nr,   '0);
        check("nr_any",     anyp_nr,  |m_press);
        for (int c = 0; c < N; c++) begin
            cnt_press[c] += press[c];
            cnt_long[c]  += lng[c];
            cnt_rep[c]   += rep[c];
        end
        cnt_long_nr += lng_nr[0];
        cnt_rep_nr  += rep_nr[0];
        cnt_any     += anyp;
    endtask

    // Apply inputs at a falling edge, then observe after the next rising edge.
    task automatic step(input logic [N-1:0] b, input logic r);
        btn_in = b;
        rst    = r;
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input logic [N-1:0] b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b1);
    endtask

    // Drive b from reset release and report the edge index of the first press.
    task automatic press_latency(input logic [N-1:0] b, output int found);
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            step(b, 1'b1);
            if (press != '0 && found == 0) begin
                found = k;
                break;
            end
        end
    endtask

    int lat;
    logic [N-1:0] rb;
    int seg_left [N];
    logic [N-1:0] seg_lvl;

    initial begin
        @(negedge clk);
        // Reset held with all buttons pressed.
        btn_in = '1; rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) step('1, 1'b0);
        check("reset_level", level, '0);
        check("reset_any",   anyp,  1'b0);

        press_latency('1, lat);
        check("reset_press_latency", lat, 7);
        check("reset_press_all", press, 4'hF);

        // Clean hold on all channels, then release and time the release pulse.
        clear_counts();
        hold('1, 40);
        check("nr_single_long", cnt_long_nr, 1);
        check("nr_no_repeat",   cnt_rep_nr,  0);
        check("ch0_long_once",  cnt_long[0], 1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step('0, 1'b1);
            if (rel != '0) begin lat = k; break; end
        end
        check("release_latency", lat, 7);
        hold('0, 10);

        // Bounce on ch1: exactly one press.
        clear_counts();
        begin
            bit bpat [10] = '{1,0,1,1,0,1,1,1,1,1};
            for (int i = 0; i < 10; i++) step({2'b00, bpat[i], 1'b0}, 1'b1);
        end
        hold(4'b0010, 15);
        hold(4'b0000, 15);
        check("bounce_one_press", cnt_press[1], 1);

        // 3-cycle glitch: no press.
        clear_counts();
        hold(4'b0010, 3);
        hold(4'b0000, 15);
        check("glitch_no_press", cnt_press[1], 0);

        // Short press on ch2: no long_press or repeat.
        clear_counts();
        hold(4'b0100, 10);
        hold(4'b0000, 15);
        check("short_press",   cnt_press[2], 1);
        check("short_no_long", cnt_long[2],  0);
        check("short_no_rep",  cnt_rep[2],   0);

        // Concurrency: ch0+ch3 together, ch1 two cycles later.
        clear_counts();
        hold(4'b1001, 2);
        hold(4'b1011, 25);
        hold(4'b0000, 15);
        check("conc_any_cycles", cnt_any, 2);
        check("conc_ch0_long",   cnt_long[0], 1);
        check("conc_ch1_long",   cnt_long[1], 1);

        // Reset mid-hold, then buttons still held after reset release.
        hold(4'b0101, 25);
        step(4'b0101, 1'b0);
        check("midrst_level", level, '0);
        check("midrst_long",  lng,   '0);
        check("midrst_rep",   rep,   '0);
        press_latency(4'b0101, lat);
        check("midrst_press_latency", lat, 7);
        hold(4'b0101, 20);

        // Randomised segments with bounce and occasional reset.
        for (int c = 0; c < N; c++) seg_left[c] = 0;
        seg_lvl = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++) begin
                if (seg_left[c] == 0) begin
                    seg_lvl[c]  = $urandom_range(0, 1);
                    seg_left[c] = $urandom_range(1, 40);
                end
                seg_left[c]--;
                rb[c] = ($urandom_range(0, 7) == 0) ? ~seg_lvl[c] : seg_lvl[c];
            end
            step(rb, ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
